// File: rtl/router_psum_load.sv
// router_psum_load: fetches X_dim consecutive partial sums from the GLB,
// packs them into one lane vector (lane 0 in the LSBs) and hands the vector
// to the PE psum scratchpads with a one-cycle load strobe.
module router_psum_load #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 5,
  parameter int NUM_ITER          = 8,
  parameter int PSUM_READ_ADDR    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             read_psum_ctrl,
  output logic [ADDR_BITWIDTH_GLB-1:0]     r_addr_glb_psum,
  output logic                             read_en_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]         r_data_glb_psum,
  output logic [DATA_BITWIDTH*X_dim-1:0]   w_data_spad_psum,
  output logic                             load_en_spad_psum,
  output logic                             busy
);

  localparam int CNT_W  = $clog2(X_dim);
  localparam int ITER_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam int VEC_W  = DATA_BITWIDTH * X_dim;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_GLB  = 2'd1,
    WAIT_DATA = 2'd2,
    LOAD_SPAD = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [ADDR_BITWIDTH_GLB-1:0] addr_q, addr_d;
  logic                         read_en_q, read_en_d;
  logic                         load_en_q, load_en_d;
  logic                         busy_q, busy_d;
  logic [ITER_W-1:0]            iter_q, iter_d;
  logic [CNT_W-1:0]             issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]             cap_cnt_q, cap_cnt_d;
  logic                         rd_en_dly_q, rd_en_dly_d;
  logic [VEC_W-1:0]             wdata_q, wdata_d;

  logic [ADDR_BITWIDTH_GLB-1:0] vec_base_s;
  logic                         start_s;

  // Base address of the current vector; the product is formed at 32 bits and
  // truncated so the GLB address wraps modulo 2^ADDR_BITWIDTH_GLB.
  always_comb begin
    vec_base_s = ADDR_BITWIDTH_GLB'(32'(PSUM_READ_ADDR) + (32'(iter_q) * 32'(X_dim)));
    start_s    = (state_q == IDLE) && read_psum_ctrl;
  end

  // Sequencer next-state: issue X_dim reads, wait one cycle for the last word,
  // then strobe the load and advance the vector index.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    read_en_d   = read_en_q;
    load_en_d   = 1'b0;
    iter_d      = iter_q;
    issue_cnt_d = issue_cnt_q;
    case (state_q)
      IDLE: begin
        if (read_psum_ctrl) begin
          state_d     = READ_GLB;
          addr_d      = vec_base_s;
          read_en_d   = 1'b1;
          issue_cnt_d = {CNT_W{1'b0}};
        end else begin
          read_en_d   = 1'b0;
        end
      end
      READ_GLB: begin
        if (issue_cnt_q == CNT_W'(X_dim - 1)) begin
          state_d     = WAIT_DATA;
          read_en_d   = 1'b0;
        end else begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          addr_d      = addr_q + ADDR_BITWIDTH_GLB'(1);
          read_en_d   = 1'b1;
        end
      end
      WAIT_DATA: begin
        state_d   = LOAD_SPAD;
        read_en_d = 1'b0;
        load_en_d = 1'b1;
      end
      LOAD_SPAD: begin
        state_d   = IDLE;
        read_en_d = 1'b0;
        if (iter_q == ITER_W'(NUM_ITER - 1)) begin
          iter_d = {ITER_W{1'b0}};
        end else begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        read_en_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Capture path: GLB data arrives one cycle after the read enable, so a
  // delayed enable steers each returning word into the next lane in order.
  always_comb begin
    rd_en_dly_d = read_en_q;
    wdata_d     = wdata_q;
    if (start_s) begin
      cap_cnt_d = {CNT_W{1'b0}};
    end else if (rd_en_dly_q) begin
      for (int j = 0; j < X_dim; j++) begin
        wdata_d[j*DATA_BITWIDTH +: DATA_BITWIDTH] =
          (cap_cnt_q == CNT_W'(j)) ? r_data_glb_psum
                                   : wdata_q[j*DATA_BITWIDTH +: DATA_BITWIDTH];
      end
      cap_cnt_d = cap_cnt_q + CNT_W'(1);
    end else begin
      cap_cnt_d = cap_cnt_q;
    end
  end

  // State and output registers; a synchronous reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= ADDR_BITWIDTH_GLB'(PSUM_READ_ADDR);
      read_en_q   <= 1'b0;
      load_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      iter_q      <= {ITER_W{1'b0}};
      issue_cnt_q <= {CNT_W{1'b0}};
      cap_cnt_q   <= {CNT_W{1'b0}};
      rd_en_dly_q <= 1'b0;
      wdata_q     <= {VEC_W{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      read_en_q   <= read_en_d;
      load_en_q   <= load_en_d;
      busy_q      <= busy_d;
      iter_q      <= iter_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      rd_en_dly_q <= rd_en_dly_d;
      wdata_q     <= wdata_d;
    end
  end

  assign r_addr_glb_psum   = addr_q;
  assign read_en_glb_psum  = read_en_q;
  assign w_data_spad_psum  = wdata_q;
  assign load_en_spad_psum = load_en_q;
  assign busy              = busy_q;

endmodule

// File: doc/router_psum_load.md
# router_psum_load

Reverse-direction partial-sum router for the PE cluster. On request from the cluster controller it reads `X_dim` consecutive partial sums from the global buffer (GLB) and packs them into one `DATA_BITWIDTH*X_dim` vector. It then presents that vector to the PE psum scratchpads with a single-cycle load strobe, so the next accumulation pass resumes from previously stored psums. It is the read-side counterpart of the psum write-back router and uses the same GLB word layout: word `j` of a vector sits at `PSUM_READ_ADDR + iter*X_dim + j`, and lane `j` occupies bits `[(j+1)*DATA_BITWIDTH-1 -: DATA_BITWIDTH]`.

## Interface
- `DATA_BITWIDTH`, 16, width of one psum word
- `ADDR_BITWIDTH_GLB`, 10, GLB address width
- `X_dim`, 5, psums per vector (number of PE lanes); must be ≥ 2
- `NUM_ITER`, 8, vectors per pass; iteration counter wraps after `NUM_ITER-1`
- `PSUM_READ_ADDR`, 0, GLB base address of vector 0
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `read_psum_ctrl`  in  1  request to fetch the next vector; sampled only in IDLE
- `r_addr_glb_psum`  out  ADDR_BITWIDTH_GLB  GLB read address
- `read_en_glb_psum`  out  1  GLB read enable
- `r_data_glb_psum`  in  DATA_BITWIDTH  GLB read data; valid the cycle after the address/enable are presented
- `w_data_spad_psum`  out  DATA_BITWIDTH*X_dim  packed psum vector to the PE spads
- `load_en_spad_psum`  out  1  one-cycle strobe: `w_data_spad_psum` is complete
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- States:
  - **IDLE**: `read_psum_ctrl`=1 → READ_GLB with `r_addr_glb_psum` = `PSUM_READ_ADDR + iter*X_dim`, `read_en_glb_psum`=1, `issue_cnt`=0. Otherwise stay; `read_en_glb_psum`=0.
  - **READ_GLB**: one address per cycle for `X_dim` cycles, incrementing `r_addr_glb_psum` by 1 each cycle. When `issue_cnt == X_dim-1` → WAIT and drop `read_en_glb_psum` to 0.
  - **WAIT**: one cycle, so the last word can be captured → LOAD_SPAD.
  - **LOAD_SPAD**: `load_en_spad_psum`=1 for exactly this cycle. `iter` advances (`NUM_ITER-1` → 0) → IDLE.
- Capture: a 1-cycle delayed copy of `read_en_glb_psum` plus a capture index `cap_cnt`. When the delayed enable is 1, write `r_data_glb_psum` into lane `cap_cnt`, then increment `cap_cnt`. `cap_cnt` resets to 0 on entry to READ_GLB.
- `w_data_spad_psum` is a register. It holds its value outside capture, and lanes are overwritten in order 0..X_dim-1.
- Address arithmetic is unsigned, modulo 2^ADDR_BITWIDTH_GLB. `iter*X_dim` is computed at full width and then truncated.
- `read_psum_ctrl` is ignored while `busy`=1. A request pulse arriving in LOAD_SPAD is lost; the controller must hold or re-issue it.

## Timing
- Reset values:
  - `r_addr_glb_psum` = `PSUM_READ_ADDR`
  - `read_en_glb_psum`, `load_en_spad_psum`, `busy` = 0
  - `w_data_spad_psum` = 0
  - `iter`, `issue_cnt`, `cap_cnt` = 0
  - state = IDLE
- Reset mid-operation aborts the transfer on the next edge. No load strobe is produced and `iter` returns to 0.
- Let cycle 0 be the cycle in which `read_psum_ctrl`=1 is sampled in IDLE:
  - Cycles 1..X_dim: `read_en_glb_psum`=1, address base+0 .. base+X_dim-1.
  - Cycles 2..X_dim+1: data for word 0..X_dim-1 is valid and is captured at the end of each cycle.
  - Cycle X_dim+2: `load_en_spad_psum`=1 and the vector is complete.
  - Cycle X_dim+3: IDLE; a new request can be sampled here.
- Latency from request to load strobe is X_dim+2 cycles. Back-to-back throughput is one vector per X_dim+3 cycles.
- `busy` is high in cycles 1..X_dim+2.

## Test plan
- Reset, then idle 10 cycles: every output stays at its reset value, no `read_en_glb_psum` pulses, and `r_addr_glb_psum`=0.
- Defaults with GLB model `mem[a]=a+16'h100`, one request: reads at addresses 0..4 in cycles 1..5; `load_en_spad_psum` only in cycle 7. Vector = {16'h104,16'h103,16'h102,16'h101,16'h100}, with lane 0 in the LSBs.
- `PSUM_READ_ADDR`=100, three sequential requests: read windows are 100–104, 105–109 and 110–114, and each vector matches memory.
- `NUM_ITER`=2, three requests: the third request rereads 0–4, confirming `iter` wrap.
- Hold `read_psum_ctrl` high continuously: exactly one transfer per 8 cycles. Pulses injected during READ_GLB/WAIT produce no extra reads.
- Assert `reset` in cycle 3 of a transfer: next cycle is IDLE with no load strobe. A following request reads addresses 0–4 again.
